// File: rtl/cache_types.sv
// Shared types and address/line helpers for the direct-mapped L1 cache.
package cache_types;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  // Tag field, right-justified; caller truncates to its TAG_W.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned idx_w);
    return a >> (OFFSET_W + idx_w);
  endfunction

  // Set index, right-justified; caller truncates to its IDX_W.
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned idx_w);
    return (a >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Word-within-line select.
  function automatic logic [2:0] addr_word(input logic [31:0] a);
    return 3'(a >> 2);
  endfunction

  // Extract one 32-bit word from a line.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic [2:0] w);
    return 32'(line >> {w, 5'b0});
  endfunction

  // Merge the enabled bytes of d into word w of line.
  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0]        w,
                                                   input logic [31:0]       d,
                                                   input logic [3:0]        mbe);
    logic [31:0]       m32;
    logic [LINE_W-1:0] wm;
    logic [LINE_W-1:0] wd;
    m32 = {{8{mbe[3]}}, {8{mbe[2]}}, {8{mbe[1]}}, {8{mbe[0]}}};
    wm  = LINE_W'(m32) << {w, 5'b0};
    wd  = LINE_W'(d) << {w, 5'b0};
    return (line & ~wm) | (wd & wm);
  endfunction

endpackage

// File: rtl/cache_array.sv
// Line storage: valid/dirty bits (async clear) plus tag/data arrays (no reset).
module cache_array
  import cache_types::*;
#(
  parameter  int unsigned NUM_SETS = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_SETS),
  localparam int unsigned TAG_W    = 27 - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_valid_i,
  input  logic              wr_valid_i,
  input  logic              we_dirty_i,
  input  logic              wr_dirty_i,
  input  logic              we_tag_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              we_data_i,
  input  logic [LINE_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  // Status bits: cleared on reset, updated per-field on write enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (we_valid_i) valid_q[idx_i] <= wr_valid_i;
      if (we_dirty_i) dirty_q[idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data payload: plain clocked writes, contents undefined after reset.
  always_ff @(posedge clk) begin
    if (we_tag_i)  tag_q[idx_i]  <= wr_tag_i;
    if (we_data_i) data_q[idx_i] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache with zero-wait hits.
module l1_cache
  import cache_types::*;
#(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_mbe,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_resp,
  output logic [31:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [255:0]  pmem_wdata,
  input  logic [255:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 27 - IDX_W;

  cache_state_t state_q, state_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [2:0]        req_word;
  logic              addr_unused;
  logic              req, hit;

  logic              line_valid, line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;

  logic              we_valid, wr_valid, we_dirty, wr_dirty, we_tag, we_data;
  logic [LINE_W-1:0] wr_data;

  assign req_tag     = TAG_W'(addr_tag(mem_address, IDX_W));
  assign req_idx     = IDX_W'(addr_index(mem_address, IDX_W));
  assign req_word    = addr_word(mem_address);
  assign addr_unused = ^mem_address[1:0];

  assign req = mem_read | mem_write;
  assign hit = line_valid && (line_tag == req_tag);

  cache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx_i      (req_idx),
    .we_valid_i (we_valid),
    .wr_valid_i (wr_valid),
    .we_dirty_i (we_dirty),
    .wr_dirty_i (wr_dirty),
    .we_tag_i   (we_tag),
    .wr_tag_i   (req_tag),
    .we_data_i  (we_data),
    .wr_data_i  (wr_data),
    .rd_valid_o (line_valid),
    .rd_dirty_o (line_dirty),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data)
  );

  // State register; reset abandons any miss in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, CPU/pmem outputs and array write controls.
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    we_valid     = 1'b0;
    wr_valid     = 1'b0;
    we_dirty     = 1'b0;
    wr_dirty     = 1'b0;
    we_tag       = 1'b0;
    we_data      = 1'b0;
    wr_data      = line_data;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (mem_read) mem_rdata = line_word(line_data, req_word);
            if (mem_write && (mem_mbe != 4'b0000)) begin
              we_data  = 1'b1;
              wr_data  = merge_word(line_data, req_word, mem_wdata, mem_mbe);
              we_dirty = 1'b1;
              wr_dirty = 1'b1;
            end
          end else if (line_valid && line_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {line_tag, req_idx, 5'b0};
        pmem_wdata   = line_data;
        if (pmem_resp) begin
          we_dirty = 1'b1;
          wr_dirty = 1'b0;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:5], 5'b0};
        if (pmem_resp) begin
          we_data  = 1'b1;
          wr_data  = pmem_rdata;
          we_tag   = 1'b1;
          we_valid = 1'b1;
          wr_valid = 1'b1;
          we_dirty = 1'b1;
          wr_dirty = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_l1_cache.sv
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [3:0]   mem_mbe;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  l1_cache #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_mbe      (mem_mbe),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Backing memory (lines) and the CPU-visible word memory. Each set
  // remembers which line it holds and whether that line has been modified.
  logic [255:0] pm   [logic [31:0]];
  logic [31:0]  gold [logic [31:0]];
  logic         res_v  [8];
  logic [31:0]  res_la [8];
  logic         res_d  [8];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a >> 5) * 32'h800 + ((a >> 2) & 32'h7);
  endfunction

  function automatic logic [255:0] pm_line(input logic [31:0] la);
    logic [255:0] l;
    if (pm.exists(la)) return pm[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] wa);
    logic [255:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = pm_line(wa & 32'hFFFF_FFE0);
    return l[32*int'((wa >> 2) & 32'h7) +: 32];
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_rd(la + 32'(4*w));
    return l;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin
      res_v[i] = 1'b0;
      res_d[i] = 1'b0;
      res_la[i] = '0;
    end
    gold.delete();
  endtask

  typedef struct {
    logic         is_read;
    logic [31:0]  rdata;
    logic         hit;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic [31:0]  al_addr;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- driver ----------------
  task automatic do_req(input logic [31:0] a, input logic wr, input logic [3:0] mbe, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] la, wa, m;
    int          s, n;
    la = a & 32'hFFFF_FFE0;
    wa = a & 32'hFFFF_FFFC;
    s  = int'((a >> 5) & 32'h7);
    e.is_read = !wr;
    e.hit     = res_v[s] && (res_la[s] == la);
    e.wb      = 1'b0;
    e.wb_addr = '0;
    e.wb_line = '0;
    e.al_addr = la;
    if (!e.hit) begin
      e.wb = res_v[s] && res_d[s];
      if (e.wb) begin
        e.wb_addr = res_la[s];
        e.wb_line = gold_line(res_la[s]);
      end
      res_v[s]  = 1'b1;
      res_la[s] = la;
      res_d[s]  = 1'b0;
    end
    e.rdata = gold_rd(wa);
    if (wr && (mbe != 4'b0000)) begin
      m = {{8{mbe[3]}}, {8{mbe[2]}}, {8{mbe[1]}}, {8{mbe[0]}}};
      gold[wa] = (gold_rd(wa) & ~m) | (wd & m);
      res_d[s] = 1'b1;
    end
    exp_q.push_back(e);
    mem_address = a;
    mem_read    = !wr;
    mem_write   = wr;
    mem_mbe     = mbe;
    mem_wdata   = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp && n < 200);
    if (!mem_resp) chk("resp_timeout", 0, 1);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_mid_alloc(input logic [31:0] a);
    int n;
    mem_address = a;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_read && n < 50);
    chk("alloc_before_rst", pmem_read, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_mem_resp", mem_resp, 0);
    mem_read = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    reset_model();
  endtask

  // ---------------- physical memory responder ----------------
  initial begin
    int d;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (pmem_read || pmem_write)) begin
        d = int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        if (!rst && (pmem_read || pmem_write)) begin
          if (pmem_write) pm[pmem_address] = pmem_wdata;
          else            pmem_rdata = pm_line(pmem_address);
          #1 pmem_resp = 1'b1;
          @(posedge clk);
          #1 pmem_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int           cyc = 0;
  int           busy = 0;
  int           last_al = -10;
  logic         wb_seen = 1'b0, al_seen = 1'b0;
  logic [31:0]  wb_addr_s, al_addr_s;
  logic [255:0] wb_line_s;
  exp_t         me;

  always @(negedge clk) begin
    if (rst) begin
      busy    = 0;
      wb_seen = 1'b0;
      al_seen = 1'b0;
    end else begin
      if (pmem_read || pmem_write) chk("pmem_exclusive", pmem_read & pmem_write, 0);
      if (pmem_write) begin
        if (!wb_seen) begin
          wb_seen   = 1'b1;
          wb_addr_s = pmem_address;
          wb_line_s = pmem_wdata;
        end else begin
          chk("wb_addr_stable", pmem_address, wb_addr_s);
        end
      end
      if (pmem_read) begin
        al_seen   = 1'b1;
        al_addr_s = pmem_address;
        last_al   = cyc;
      end
      if (mem_resp) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", 1, 0);
        end else begin
          me = exp_q.pop_front();
          if (me.is_read) chk("rdata", mem_rdata, me.rdata);
          if (me.hit) begin
            chk("hit_latency", busy, 0);
            chk("hit_pmem_idle", wb_seen | al_seen, 0);
          end else begin
            chk("alloc_seen", al_seen, 1);
            chk("alloc_addr", al_addr_s, me.al_addr);
            chk("miss_latency", cyc - last_al, 1);
            chk("wb_seen", wb_seen, me.wb);
            if (me.wb && wb_seen) begin
              chk("wb_addr", wb_addr_s, me.wb_addr);
              chk("wb_line", wb_line_s, me.wb_line);
            end
          end
        end
        busy    = 0;
        wb_seen = 1'b0;
        al_seen = 1'b0;
      end else if (mem_read || mem_write) begin
        busy++;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    rst         = 1'b1;
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_mbe     = '0;
    mem_wdata   = '0;
    reset_model();
    @(posedge clk);
    @(negedge clk);
    chk("reset_mem_resp", mem_resp, 0);
    chk("reset_mem_rdata", mem_rdata, 0);
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_write", pmem_write, 0);
    chk("reset_pmem_wdata", pmem_wdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Cold miss, hits, partial write, dirty conflict eviction.
    do_req(32'h0000_0040, 1'b0, 4'b0000, 32'h0);
    do_req(32'h0000_0044, 1'b0, 4'b0000, 32'h0);
    do_req(32'h0000_0048, 1'b1, 4'b0110, 32'hAABB_CCDD);
    do_req(32'h0000_0048, 1'b0, 4'b0000, 32'h0);
    chk("plan_merged_word", gold_rd(32'h48), 32'h00BB_CC02);
    do_req(32'h0000_0140, 1'b0, 4'b0000, 32'h0);
    idle(2);

    // Reset while a fill is outstanding; nothing may survive.
    rst_mid_alloc(32'h0000_0040);
    idle(1);
    do_req(32'h0000_0140, 1'b0, 4'b0000, 32'h0);

    // Empty byte mask leaves the line clean: the next conflict must not write back.
    do_req(32'h0000_0144, 1'b1, 4'b0000, 32'hDEAD_BEEF);
    do_req(32'h0000_0144, 1'b0, 4'b0000, 32'h0);
    do_req(32'h0000_0040, 1'b0, 4'b0000, 32'h0);

    // Randomised traffic over 4 tags x 8 sets for conflicts and wrap.
    for (int i = 0; i < 400; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_req(a, 1'b1, 4'($urandom_range(0, 15)), $urandom);
      else
        do_req(a, 1'b0, 4'b0000, 32'h0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-back, write-allocate cache.
- Serves as the responder for the CPU-side cache port that the pipeline datapath drives. One instance sits behind the I-cache port and one behind the D-cache port.
- Accepts word requests (address, read/write, byte mask, wdata) and returns resp/rdata.
- Fills and evicts 256-bit lines over a burst-less physical-memory port.

Parameters:
- NUM_SETS, 8, number of lines. Must be a power of 2 and at least 2. IDX_W = log2(NUM_SETS); TAG_W = 27 - IDX_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- mem_address  input  32  CPU byte address; bits [1:0] are ignored
- mem_read  input  1  read request
- mem_write  input  1  write request
- mem_mbe  input  4  byte enables for write
- mem_wdata  input  32  write data, already lane-aligned
- mem_rdata  output  32  read data; valid only while mem_resp=1
- mem_resp  output  1  request complete
- pmem_address  output  32  line-aligned address; bits [4:0]=0
- pmem_read  output  1  line fill request
- pmem_write  output  1  line writeback request
- pmem_wdata  output  256  evicted line
- pmem_rdata  input  256  fill line
- pmem_resp  input  1  physical memory done

Behaviour:
- Address split:
  - tag = addr[31:5+IDX_W]
  - index = addr[4+IDX_W:5]
  - word = addr[4:2]
  - Line word w occupies bits [32w+31:32w].
- Storage:
  - valid[] and dirty[] are cleared asynchronously by rst.
  - tag[] and data[] are not reset.
- Reset values: mem_resp=0, pmem_read=0, pmem_write=0, pmem_wdata=0, mem_rdata=0, state=IDLE.
- Request contract:
  - The requester holds address, read/write, mbe and wdata stable from request until the cycle mem_resp=1.
  - mem_read and mem_write both high is illegal; a simulation assertion fires.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: all outputs stay deasserted.
- IDLE, request with valid[index] && tag match (hit):
  - mem_resp=1 combinationally in the same cycle; zero-wait hit.
  - Read hit: mem_rdata = selected word.
  - Write hit: on the next clk edge, each byte with mem_mbe[b]=1 is merged into the word; dirty[index] is set if mem_mbe != 0.
  - mem_mbe=0 write: resp is given and nothing changes.
  - A back-to-back hit in the following cycle is allowed.
- IDLE, request misses:
  - If valid && dirty, go to WRITEBACK.
  - Otherwise go to ALLOCATE.
  - mem_resp stays 0.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored tag, index, 5'b0}, pmem_wdata=stored line; all held stable.
  - On pmem_resp, clear dirty and go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={addr[31:5], 5'b0}.
  - On pmem_resp, write pmem_rdata into data[index], write tag, set valid=1, dirty=0, and return to IDLE.
  - The request then hits on the next cycle.
- Miss latency: resp arrives 1 cycle after the final pmem_resp.
- Read and write never overlap on the pmem side; exactly one of pmem_read/pmem_write is high in WRITEBACK/ALLOCATE.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-miss: the FSM returns to IDLE immediately, pmem strobes drop, and all lines are invalidated. No partial line is committed.
- Index wrap: addresses differing only in tag map to the same set; the conflict causes eviction.

Decomposition:
- Package cache_types:
  - cache_state_t enum {IDLE, WRITEBACK, ALLOCATE}
  - LINE_W=256, OFFSET_W=5
  - Helper functions for tag/index/word extraction and byte-merge of a 32-bit word into a 256-bit line under a 4-bit mask
- Sub-module cache_array: parameterised by NUM_SETS.
  - Holds valid/dirty (async reset) and tag/data (no reset).
  - Combinational read port; synchronous write port with per-field write enables.
- l1_cache holds the FSM and hit logic.

Test Plan:
- Cold read 0x0000_0040, memory line words = 0x1000+w: ALLOCATE with pmem_address 0x40. After pmem_resp, the next cycle gives mem_resp=1, mem_rdata=0x1000.
- Read hit 0x44 immediately after: mem_resp=1 in the same cycle, mem_rdata=0x1001, no pmem activity.
- Write 0x48, mbe=4'b0110, wdata=0xAABBCCDD over 0x1002: hit, resp same cycle. A subsequent read of 0x48 returns 0x00BBCC02, and dirty is set.
- Read 0x0000_0140 (same index, NUM_SETS=8): WRITEBACK with pmem_address 0x40, pmem_wdata word2=0x00BBCC02. Then ALLOCATE with pmem_address 0x140, then resp.
- Assert rst during ALLOCATE: pmem_read=0 and mem_resp=0 at once. Re-reading 0x140 misses again, with no writeback.
- Write with mbe=0 on a clean hit: resp=1, data unchanged. A later conflicting miss goes straight to ALLOCATE with no WRITEBACK.
